// File: rtl/falc56_bus_sequencer.sv
// FALC56 multiplexed address/data bus master: takes single register read/write
// commands, owns the shared bus via REQ/GNT and runs the ALE -> strobe -> hold cycle.
module falc56_bus_sequencer #(
    parameter int ALE_CYCLES       = 1,
    parameter int ADDR_HOLD_CYCLES = 1,
    parameter int STROBE_CYCLES    = 3,
    parameter int HOLD_CYCLES      = 1,
    parameter int PARK_CYCLES      = 4
) (
    input  logic       PHY_CLK33_I,
    input  logic       PHY_RST_I,
    input  logic       CMD_VALID_I,
    output logic       CMD_READY_O,
    input  logic       CMD_WE_I,
    input  logic       CMD_CS_I,
    input  logic [7:0] CMD_ADDR_I,
    input  logic [7:0] CMD_WDATA_I,
    output logic       RSP_VALID_O,
    output logic [7:0] RSP_RDATA_O,
    output logic       F56_REQ_O,
    input  logic       F56_GNT_I,
    output logic [7:0] F56_BADD_O,
    input  logic [7:0] F56_BADD_I,
    output logic       F56_BADD_DIR_O,
    output logic       F56_ALE_O,
    output logic       F56_RDn_O,
    output logic       F56_WRn_O,
    output logic [1:0] F56_CSn_O
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_AHOLD,
        S_STROBE,
        S_HOLD,
        S_RELEASE
    } state_t;

    localparam logic [3:0] ALE_LOAD    = 4'(ALE_CYCLES - 1);
    localparam logic [3:0] AHOLD_LOAD  = 4'(ADDR_HOLD_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
    localparam bit         PARK_NONE   = (PARK_CYCLES == 0);
    localparam logic [3:0] PARK_LAST   = PARK_NONE ? 4'd0 : 4'(PARK_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [3:0] park_reg, park_next;
    logic       owned_reg, owned_next;
    logic       pend_reg, pend_next;
    logic       we_reg, we_next;
    logic       cs_reg, cs_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       req_reg, req_next;
    logic       ale_reg, ale_next;
    logic       rdn_reg, rdn_next;
    logic       wrn_reg, wrn_next;
    logic [1:0] csn_reg, csn_next;
    logic [7:0] badd_reg, badd_next;
    logic       dir_reg, dir_next;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [7:0] rdata_reg, rdata_next;

    assign CMD_READY_O = (state_reg == S_IDLE) && !PHY_RST_I;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        park_next      = park_reg;
        owned_next     = owned_reg;
        pend_next      = pend_reg;
        we_next        = we_reg;
        cs_next        = cs_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        req_next       = req_reg;
        rsp_valid_next = 1'b0;
        rdata_next     = rdata_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (CMD_VALID_I) begin
                    we_next    = CMD_WE_I;
                    cs_next    = CMD_CS_I;
                    addr_next  = CMD_ADDR_I;
                    wdata_next = CMD_WDATA_I;
                    if (!owned_reg) begin
                        state_next = S_REQ;
                        req_next   = 1'b1;
                    end else if (F56_GNT_I) begin
                        state_next = S_ADDR;
                        cnt_next   = ALE_LOAD;
                    end else begin
                        // Grant lost while parked: drop REQ once, then re-request for this command.
                        state_next = S_RELEASE;
                        pend_next  = 1'b1;
                    end
                end else if (owned_reg) begin
                    if (PARK_NONE || park_reg == PARK_LAST || !F56_GNT_I) begin
                        state_next = S_RELEASE;
                    end else begin
                        park_next = park_reg + 4'd1;
                    end
                end
            end
            S_REQ: begin
                if (F56_GNT_I) begin
                    state_next = S_ADDR;
                    cnt_next   = ALE_LOAD;
                    owned_next = 1'b1;
                end
            end
            S_ADDR: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_AHOLD;
                    cnt_next   = AHOLD_LOAD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_AHOLD: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_STROBE;
                    cnt_next   = STROBE_LOAD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_reg == 4'd0) begin
                    state_next     = S_HOLD;
                    cnt_next       = HOLD_LOAD;
                    rsp_valid_next = 1'b1;
                    if (!we_reg) begin
                        rdata_next = F56_BADD_I;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_reg == 4'd0) begin
                    state_next = F56_GNT_I ? S_IDLE : S_RELEASE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RELEASE: begin
                pend_next = 1'b0;
                if (pend_reg) begin
                    state_next = S_REQ;
                    req_next   = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (state_next == S_RELEASE) begin
            req_next   = 1'b0;
            owned_next = 1'b0;
        end
        if (state_next != S_IDLE) begin
            park_next = 4'd0;
        end

        // Bus pins are registered from the state being entered.
        ale_next  = (state_next == S_ADDR);
        rdn_next  = !((state_next == S_STROBE) && !we_next);
        wrn_next  = !((state_next == S_STROBE) && we_next);
        csn_next  = (state_next == S_STROBE) ? (cs_next ? 2'b01 : 2'b10) : 2'b11;
        badd_next = 8'h00;
        dir_next  = 1'b0;
        unique case (state_next)
            S_ADDR, S_AHOLD: begin
                badd_next = addr_next;
                dir_next  = 1'b1;
            end
            S_STROBE, S_HOLD: begin
                badd_next = we_next ? wdata_next : 8'h00;
                dir_next  = we_next;
            end
            default: begin
                badd_next = 8'h00;
                dir_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PHY_CLK33_I or posedge PHY_RST_I) begin
        if (PHY_RST_I) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 4'd0;
            park_reg      <= 4'd0;
            owned_reg     <= 1'b0;
            pend_reg      <= 1'b0;
            we_reg        <= 1'b0;
            cs_reg        <= 1'b0;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            req_reg       <= 1'b0;
            ale_reg       <= 1'b0;
            rdn_reg       <= 1'b1;
            wrn_reg       <= 1'b1;
            csn_reg       <= 2'b11;
            badd_reg      <= 8'h00;
            dir_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= 8'h00;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            park_reg      <= park_next;
            owned_reg     <= owned_next;
            pend_reg      <= pend_next;
            we_reg        <= we_next;
            cs_reg        <= cs_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            req_reg       <= req_next;
            ale_reg       <= ale_next;
            rdn_reg       <= rdn_next;
            wrn_reg       <= wrn_next;
            csn_reg       <= csn_next;
            badd_reg      <= badd_next;
            dir_reg       <= dir_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign F56_REQ_O      = req_reg;
    assign F56_ALE_O      = ale_reg;
    assign F56_RDn_O      = rdn_reg;
    assign F56_WRn_O      = wrn_reg;
    assign F56_CSn_O      = csn_reg;
    assign F56_BADD_O     = badd_reg;
    assign F56_BADD_DIR_O = dir_reg;
    assign RSP_VALID_O    = rsp_valid_reg;
    assign RSP_RDATA_O    = rdata_reg;

endmodule

// File: tb/tb_falc56_bus_sequencer.sv
// Directed bench for falc56_bus_sequencer with a registered one-requester arbiter model.
module tb_falc56_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic       cmd_cs = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       req;
    logic       gnt = 1'b0;
    logic [7:0] badd_o;
    logic [7:0] badd_i = 8'hEE;
    logic       badd_dir;
    logic       ale, rdn, wrn;
    logic [1:0] csn;
    logic       arb_en = 1'b1;

    int nchk  = 0;
    int npass = 0;

    falc56_bus_sequencer dut (
        .PHY_CLK33_I   (clk),
        .PHY_RST_I     (rst),
        .CMD_VALID_I   (cmd_valid),
        .CMD_READY_O   (cmd_ready),
        .CMD_WE_I      (cmd_we),
        .CMD_CS_I      (cmd_cs),
        .CMD_ADDR_I    (cmd_addr),
        .CMD_WDATA_I   (cmd_wdata),
        .RSP_VALID_O   (rsp_valid),
        .RSP_RDATA_O   (rsp_rdata),
        .F56_REQ_O     (req),
        .F56_GNT_I     (gnt),
        .F56_BADD_O    (badd_o),
        .F56_BADD_I    (badd_i),
        .F56_BADD_DIR_O(badd_dir),
        .F56_ALE_O     (ale),
        .F56_RDn_O     (rdn),
        .F56_WRn_O     (wrn),
        .F56_CSn_O     (csn)
    );

    always #15 clk = ~clk;

    // Arbiter model: grant follows request one cycle later while enabled.
    always @(posedge clk) gnt <= req & arb_en;

    // Presents a command at a falling edge and returns at the falling edge after acceptance (n=0).
    task automatic do_cmd(input logic we, input logic cs, input logic [7:0] addr,
                          input logic [7:0] wdata, output logic ok);
        cmd_we = we; cmd_cs = cs; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        nchk++; if (ok !== 1'b1) $display("FAIL cmd_accept_timeout got ready=%b want 1", cmd_ready); else npass++;
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        $display("cmd we=%0b cs=%0b addr=%h wdata=%h accepted=%0b t=%0t", we, cs, addr, wdata, ok, $time);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nchk++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", cmd_ready); else npass++;
        nchk++; if ({req, ale, rdn, wrn, csn, badd_dir, rsp_valid} !== 8'b0011_1100)
            $display("FAIL rst_strobes got %b want 00111100", {req, ale, rdn, wrn, csn, badd_dir, rsp_valid}); else npass++;
        nchk++; if ({badd_o, rsp_rdata} !== 16'h0000) $display("FAIL rst_data got %h want 0000", {badd_o, rsp_rdata}); else npass++;
        rst = 1'b0;
        #1;
        nchk++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", cmd_ready); else npass++;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic ok;
        logic [12:0] e_ale, e_wrl, e_rsp, e_req, e_rdy;
        e_ale = 13'b0_0000_0000_0100;
        e_wrl = 13'b0_0000_0111_0000;
        e_rsp = 13'b0_0000_1000_0000;
        e_req = 13'b0_1111_1111_1111;
        e_rdy = 13'b0_1111_0000_0000;
        do_cmd(1'b1, 1'b1, 8'h3C, 8'hA5, ok);
        for (int n = 0; n <= 12; n++) begin
            nchk++; if (ale !== e_ale[n]) $display("FAIL wr_ale n=%0d got %b want %b", n, ale, e_ale[n]); else npass++;
            nchk++; if (wrn !== ~e_wrl[n]) $display("FAIL wr_wrn n=%0d got %b want %b", n, wrn, ~e_wrl[n]); else npass++;
            nchk++; if (rsp_valid !== e_rsp[n]) $display("FAIL wr_rsp n=%0d got %b want %b", n, rsp_valid, e_rsp[n]); else npass++;
            nchk++; if (req !== e_req[n]) $display("FAIL wr_req n=%0d got %b want %b", n, req, e_req[n]); else npass++;
            nchk++; if (cmd_ready !== e_rdy[n]) $display("FAIL wr_ready n=%0d got %b want %b", n, cmd_ready, e_rdy[n]); else npass++;
            if (n == 2) begin
                nchk++; if ({badd_o, badd_dir, csn} !== {8'h3C, 1'b1, 2'b11})
                    $display("FAIL wr_addr_phase got %h/%b/%b want 3c/1/11", badd_o, badd_dir, csn); else npass++;
            end
            if (n >= 4 && n <= 6) begin
                nchk++; if ({badd_o, badd_dir, csn, rdn} !== {8'hA5, 1'b1, 2'b01, 1'b1})
                    $display("FAIL wr_strobe n=%0d got %h/%b/%b/%b want a5/1/01/1", n, badd_o, badd_dir, csn, rdn); else npass++;
            end
            if (n < 12) @(negedge clk);
        end
    endtask

    task automatic test_read();
        logic ok;
        logic [12:0] e_rdl, e_rsp, e_req;
        e_rdl = 13'b0_0000_0111_0000;
        e_rsp = 13'b0_0000_1000_0000;
        e_req = 13'b0_1111_1111_1111;
        badd_i = 8'hEE;
        do_cmd(1'b0, 1'b0, 8'h12, 8'h00, ok);
        for (int n = 0; n <= 12; n++) begin
            nchk++; if (rdn !== ~e_rdl[n]) $display("FAIL rd_rdn n=%0d got %b want %b", n, rdn, ~e_rdl[n]); else npass++;
            nchk++; if (wrn !== 1'b1) $display("FAIL rd_wrn n=%0d got %b want 1", n, wrn); else npass++;
            nchk++; if (rsp_valid !== e_rsp[n]) $display("FAIL rd_rsp n=%0d got %b want %b", n, rsp_valid, e_rsp[n]); else npass++;
            nchk++; if (req !== e_req[n]) $display("FAIL rd_req n=%0d got %b want %b", n, req, e_req[n]); else npass++;
            if (n == 2) begin
                nchk++; if ({ale, badd_o, badd_dir} !== {1'b1, 8'h12, 1'b1})
                    $display("FAIL rd_addr_phase got %b/%h/%b want 1/12/1", ale, badd_o, badd_dir); else npass++;
            end
            if (n >= 4 && n <= 6) begin
                nchk++; if ({badd_dir, csn, badd_o} !== {1'b0, 2'b10, 8'h00})
                    $display("FAIL rd_strobe n=%0d got %b/%b/%h want 0/10/00", n, badd_dir, csn, badd_o); else npass++;
            end
            if (n == 7) begin
                nchk++; if (rsp_rdata !== 8'h5A) $display("FAIL rd_data got %h want 5a", rsp_rdata); else npass++;
            end
            // Only the last strobe cycle carries the value that must be captured.
            badd_i = (n == 4) ? 8'h11 : (n == 5) ? 8'h22 : (n == 6) ? 8'h5A : 8'hEE;
            if (n < 12) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [10:0] e_ale, e_wrl, e_rsp, e_req;
        e_ale = 11'b000_0000_0001;
        e_wrl = 11'b000_0001_1100;
        e_rsp = 11'b000_0010_0000;
        e_req = 11'b011_1111_1111;
        do_cmd(1'b1, 1'b0, 8'h40, 8'h11, ok);
        for (int n = 0; n <= 8; n++) begin
            nchk++; if (req !== 1'b1) $display("FAIL b2b_req1 n=%0d got %b want 1", n, req); else npass++;
            nchk++; if (rsp_valid !== (n == 7)) $display("FAIL b2b_rsp1 n=%0d got %b want %b", n, rsp_valid, (n == 7)); else npass++;
            if (n < 8) @(negedge clk);
        end
        do_cmd(1'b1, 1'b1, 8'h77, 8'h99, ok);
        for (int m = 0; m <= 10; m++) begin
            nchk++; if (ale !== e_ale[m]) $display("FAIL b2b_ale m=%0d got %b want %b", m, ale, e_ale[m]); else npass++;
            nchk++; if (wrn !== ~e_wrl[m]) $display("FAIL b2b_wrn m=%0d got %b want %b", m, wrn, ~e_wrl[m]); else npass++;
            nchk++; if (rsp_valid !== e_rsp[m]) $display("FAIL b2b_rsp2 m=%0d got %b want %b", m, rsp_valid, e_rsp[m]); else npass++;
            nchk++; if (req !== e_req[m]) $display("FAIL b2b_req2 m=%0d got %b want %b", m, req, e_req[m]); else npass++;
            if (m == 0) begin
                nchk++; if (badd_o !== 8'h77) $display("FAIL b2b_addr got %h want 77", badd_o); else npass++;
            end
            if (m >= 2 && m <= 4) begin
                nchk++; if ({badd_o, csn} !== {8'h99, 2'b01}) $display("FAIL b2b_data m=%0d got %h/%b want 99/01", m, badd_o, csn); else npass++;
            end
            if (m < 10) @(negedge clk);
        end
    endtask

    task automatic test_revoke();
        logic ok;
        logic [12:0] e_wrl, e_rsp, e_req, e_rdy, e_ale2, e_req2, e_rsp2;
        e_wrl  = 13'b0_0000_0111_0000;
        e_rsp  = 13'b0_0000_1000_0000;
        e_req  = 13'b0_0000_1111_1111;
        e_rdy  = 13'b0_0010_0000_0000;
        e_ale2 = 13'b0_0000_0000_0100;
        e_req2 = 13'b0_1111_1111_1111;
        e_rsp2 = 13'b0_0000_1000_0000;
        do_cmd(1'b1, 1'b0, 8'h21, 8'h42, ok);
        for (int n = 0; n <= 9; n++) begin
            nchk++; if (wrn !== ~e_wrl[n]) $display("FAIL rv_wrn n=%0d got %b want %b", n, wrn, ~e_wrl[n]); else npass++;
            nchk++; if (rsp_valid !== e_rsp[n]) $display("FAIL rv_rsp n=%0d got %b want %b", n, rsp_valid, e_rsp[n]); else npass++;
            nchk++; if (req !== e_req[n]) $display("FAIL rv_req n=%0d got %b want %b", n, req, e_req[n]); else npass++;
            nchk++; if (cmd_ready !== e_rdy[n]) $display("FAIL rv_ready n=%0d got %b want %b", n, cmd_ready, e_rdy[n]); else npass++;
            if (n == 4) arb_en = 1'b0;
            if (n < 9) @(negedge clk);
        end
        arb_en = 1'b1;
        badd_i = 8'hEE;
        do_cmd(1'b0, 1'b1, 8'h33, 8'h00, ok);
        for (int n = 0; n <= 12; n++) begin
            nchk++; if (ale !== e_ale2[n]) $display("FAIL rv2_ale n=%0d got %b want %b", n, ale, e_ale2[n]); else npass++;
            nchk++; if (req !== e_req2[n]) $display("FAIL rv2_req n=%0d got %b want %b", n, req, e_req2[n]); else npass++;
            nchk++; if (rsp_valid !== e_rsp2[n]) $display("FAIL rv2_rsp n=%0d got %b want %b", n, rsp_valid, e_rsp2[n]); else npass++;
            if (n == 7) begin
                nchk++; if (rsp_rdata !== 8'hEE) $display("FAIL rv2_data got %h want ee", rsp_rdata); else npass++;
            end
            if (n < 12) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [12:0] e_ale, e_wrl, e_rsp;
        e_ale = 13'b0_0000_0000_0100;
        e_wrl = 13'b0_0000_0111_0000;
        e_rsp = 13'b0_0000_1000_0000;
        do_cmd(1'b0, 1'b1, 8'h55, 8'h00, ok);
        repeat (5) @(negedge clk);
        nchk++; if (rdn !== 1'b0) $display("FAIL rm_in_strobe got rdn=%b want 0", rdn); else npass++;
        rst = 1'b1;
        #1;
        nchk++; if ({req, ale, rdn, wrn, csn, badd_dir, rsp_valid} !== 8'b0011_1100)
            $display("FAIL rm_strobes got %b want 00111100", {req, ale, rdn, wrn, csn, badd_dir, rsp_valid}); else npass++;
        nchk++; if ({badd_o, rsp_rdata} !== 16'h0000) $display("FAIL rm_data got %h want 0000", {badd_o, rsp_rdata}); else npass++;
        nchk++; if (cmd_ready !== 1'b0) $display("FAIL rm_ready_in_rst got %b want 0", cmd_ready); else npass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        nchk++; if (cmd_ready !== 1'b1) $display("FAIL rm_ready_after got %b want 1", cmd_ready); else npass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nchk++; if ({rsp_valid, req} !== 2'b00) $display("FAIL rm_quiet i=%0d got %b want 00", i, {rsp_valid, req}); else npass++;
        end
        do_cmd(1'b1, 1'b0, 8'h0F, 8'hF0, ok);
        for (int n = 0; n <= 12; n++) begin
            nchk++; if (ale !== e_ale[n]) $display("FAIL rm2_ale n=%0d got %b want %b", n, ale, e_ale[n]); else npass++;
            nchk++; if (wrn !== ~e_wrl[n]) $display("FAIL rm2_wrn n=%0d got %b want %b", n, wrn, ~e_wrl[n]); else npass++;
            nchk++; if (rsp_valid !== e_rsp[n]) $display("FAIL rm2_rsp n=%0d got %b want %b", n, rsp_valid, e_rsp[n]); else npass++;
            if (n == 5) begin
                nchk++; if ({badd_o, csn} !== {8'hF0, 2'b10}) $display("FAIL rm2_data got %h/%b want f0/10", badd_o, csn); else npass++;
            end
            if (n < 12) @(negedge clk);
        end
    endtask

    task automatic test_long_wait();
        logic ok;
        logic [10:0] e_ale, e_rsp, e_req;
        e_ale = 11'b000_0000_0001;
        e_rsp = 11'b000_0010_0000;
        e_req = 11'b011_1111_1111;
        arb_en = 1'b0;
        do_cmd(1'b1, 1'b1, 8'hC3, 8'h3C, ok);
        for (int i = 0; i < 100; i++) begin
            nchk++; if ({req, ale, cmd_ready} !== 3'b100) $display("FAIL lw_wait i=%0d got %b want 100", i, {req, ale, cmd_ready}); else npass++;
            @(negedge clk);
        end
        arb_en = 1'b1;
        @(negedge clk);
        nchk++; if (ale !== 1'b0) $display("FAIL lw_gnt_cycle got ale=%b want 0", ale); else npass++;
        @(negedge clk);
        for (int m = 0; m <= 10; m++) begin
            nchk++; if (ale !== e_ale[m]) $display("FAIL lw_ale m=%0d got %b want %b", m, ale, e_ale[m]); else npass++;
            nchk++; if (rsp_valid !== e_rsp[m]) $display("FAIL lw_rsp m=%0d got %b want %b", m, rsp_valid, e_rsp[m]); else npass++;
            nchk++; if (req !== e_req[m]) $display("FAIL lw_req m=%0d got %b want %b", m, req, e_req[m]); else npass++;
            if (m == 0) begin
                nchk++; if (badd_o !== 8'hC3) $display("FAIL lw_addr got %h want c3", badd_o); else npass++;
            end
            if (m < 10) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_revoke();
        test_reset_mid();
        test_long_wait();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got time=%0t want finish earlier", $time);
        $fatal(1, "bench timeout");
    end

endmodule
